// File: rtl/nmix_pkg.sv
// Shared types for the nmix engine: FSM state encoding and mode constants.
package nmix_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nmix_state_t;

   localparam logic MODE_FWD = 1'b0;
   localparam logic MODE_INV = 1'b1;

endpackage

// File: rtl/nmix_slice.sv
// Combinational BPC-bit mix chunk with running-parity carry, LSB first.
module nmix_slice
   import nmix_pkg::*;
#(
   parameter int unsigned BPC = 1
) (
   input  logic [BPC-1:0] xc,
   input  logic [BPC-1:0] rc,
   input  logic           cin,
   input  logic           mode,
   output logic [BPC-1:0] yc,
   output logic           cout
);

   logic par;
   logic yb;

   always_comb begin
      par = cin;
      yb  = 1'b0;
      yc  = '0;
      for (int i = 0; i < int'(BPC); i++) begin
         yb    = xc[i] ^ rc[i] ^ par;
         yc[i] = yb;
         // parity follows the plaintext bit: x going forward, recovered y going inverse
         par   = par ^ (((mode == MODE_INV) ? yb : xc[i]) & rc[i]);
      end
      cout = par;
   end

endmodule

// File: rtl/nmix_engine.sv
// Multi-cycle bit-serial mix/unmix engine processing BPC bits per cycle.
// Inverse mode is compiled in only when NMIX_INV_EN is defined.
module nmix_engine
   import nmix_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BPC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NCHUNK = WIDTH / BPC;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_bad_cfg
      $error("nmix_engine: WIDTH must be >= 2 and divisible by BPC");
   end

   nmix_state_t      state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] x_q, r_q;
   logic             mode_q;
   logic             c_q;
   logic             last;
   logic             accept;
   logic [BPC-1:0]   yc;
   logic             cout;

   assign last   = (cnt == CW'(NCHUNK - 1));
   assign accept = start && (state != RUN);

   nmix_slice #(.BPC(BPC)) u_slice (
      .xc   (x_q[BPC-1:0]),
      .rc   (r_q[BPC-1:0]),
      .cin  (c_q),
      .mode (mode_q),
      .yc   (yc),
      .cout (cout)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last)  state_n = DONE;
         DONE:    state_n = start ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Operands shift down one chunk per cycle; results enter at the top and settle LSB-aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         y      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         x_q    <= '0;
         r_q    <= '0;
         mode_q <= MODE_FWD;
         c_q    <= 1'b0;
         cnt    <= '0;
      end else begin
         busy <= (state_n == RUN);
         done <= (state_n == DONE);
         if (accept) begin
            x_q <= x;
            r_q <= r;
`ifdef NMIX_INV_EN
            mode_q <= mode;
`else
            // forward-only build: mode is tied off
            mode_q <= mode & MODE_FWD;
`endif
            c_q <= 1'b0;
            cnt <= '0;
         end else if (state == RUN) begin
            x_q <= x_q >> BPC;
            r_q <= r_q >> BPC;
            c_q <= cout;
            y   <= (y >> BPC) | (WIDTH'(yc) << (WIDTH - BPC));
            cnt <= last ? '0 : cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nmix_engine.sv
// Self-checking bench for nmix_engine at BPC=1 and BPC=8 against a bit-parity reference model.
module tb_nmix_engine;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic st1, m1, busy1, done1;
   logic [W-1:0] x1, r1, y1;
   logic st8, m8, busy8, done8;
   logic [W-1:0] x8, r8, y8;

   int total = 0;
   int bad   = 0;

   nmix_engine #(.WIDTH(W), .BPC(1)) dut1 (
      .clk(clk), .reset(reset), .start(st1), .mode(m1),
      .x(x1), .r(r1), .y(y1), .busy(busy1), .done(done1));

   nmix_engine #(.WIDTH(W), .BPC(8)) dut8 (
      .clk(clk), .reset(reset), .start(st8), .mode(m8),
      .x(x8), .r(r8), .y(y8), .busy(busy8), .done(done8));

   // c[i] is the parity of all (x & r) bits strictly below i
   function automatic logic [W-1:0] mix_fwd(input logic [W-1:0] xv, input logic [W-1:0] rv);
      logic [W-1:0] p;
      logic [W-1:0] yv;
      p  = xv & rv;
      yv = '0;
      for (int i = 0; i < int'(W); i++)
         yv[i] = xv[i] ^ rv[i] ^ (^(p & ((W'(1) << i) - W'(1))));
      return yv;
   endfunction

   function automatic logic [W-1:0] mix_inv(input logic [W-1:0] yin, input logic [W-1:0] rv);
      logic [W-1:0] xo;
      xo = '0;
      for (int i = 0; i < int'(W); i++)
         xo[i] = yin[i] ^ rv[i] ^ (^(xo & rv & ((W'(1) << i) - W'(1))));
      return xo;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] rv,
                                          input logic mv);
`ifdef NMIX_INV_EN
      return mv ? mix_inv(xv, rv) : mix_fwd(xv, rv);
`else
      return mv ? mix_fwd(xv, rv) : mix_fwd(xv, rv);
`endif
   endfunction

   function automatic logic get_done(input int sel);
      return (sel != 0) ? done8 : done1;
   endfunction

   task automatic set_in(input int sel, input logic s, input logic [W-1:0] xv,
                         input logic [W-1:0] rv, input logic mv);
      if (sel != 0) begin st8 = s; x8 = xv; r8 = rv; m8 = mv; end
      else          begin st1 = s; x1 = xv; r1 = rv; m1 = mv; end
   endtask

   task automatic set_start(input int sel, input logic s);
      if (sel != 0) st8 = s; else st1 = s;
   endtask

   // Present an operation at a falling edge and step past the accepting rising edge.
   task automatic launch(input int sel, input logic [W-1:0] xv, input logic [W-1:0] rv,
                         input logic mv, input bit hold);
      set_in(sel, 1'b1, xv, rv, mv);
      @(negedge clk);
      if (!hold) set_start(sel, 1'b0);
   endtask

   // Count rising edges from the accepting edge until done; -1 when the bound expires.
   task automatic wait_done(input int sel, input bit scramble, output int edges,
                            output logic [W-1:0] yv);
      edges = 1;
      while (!get_done(sel) && edges < 100) begin
         if (scramble) begin
            if (sel != 0) begin x8 = $urandom; r8 = $urandom; m8 = 1'($urandom_range(0, 1)); end
            else          begin x1 = $urandom; r1 = $urandom; m1 = 1'($urandom_range(0, 1)); end
         end
         @(negedge clk);
         edges++;
      end
      yv = (sel != 0) ? y8 : y1;
      if (!get_done(sel)) edges = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(0, 1'b0, '0, '0, 1'b0);
      set_in(1, 1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (y1 !== '0)     begin bad++; $display("FAIL reset_y1 got=%h exp=0", y1); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b exp=0", done1); end
      total++; if (y8 !== '0)     begin bad++; $display("FAIL reset_y8 got=%h exp=0", y8); end
      total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
      total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
   endtask

   task automatic test_directed();
      logic [W-1:0] xs [4];
      logic [W-1:0] rs [4];
      logic [W-1:0] es [4];
      logic         ms [4];
      logic [W-1:0] yv;
      int           e;
      xs[0] = 32'h0;        rs[0] = 32'h0;        ms[0] = 1'b0; es[0] = 32'h00000000;
      xs[1] = 32'hFFFFFFFF; rs[1] = 32'hFFFFFFFF; ms[1] = 1'b0; es[1] = 32'hAAAAAAAA;
      xs[2] = 32'h00000001; rs[2] = 32'h00000001; ms[2] = 1'b0; es[2] = 32'hFFFFFFFE;
`ifdef NMIX_INV_EN
      xs[3] = 32'hFFFFFFFE; rs[3] = 32'h00000001; ms[3] = 1'b1; es[3] = 32'h00000001;
`else
      xs[3] = 32'hFFFFFFFE; rs[3] = 32'h00000001; ms[3] = 1'b1; es[3] = 32'hFFFFFFFF;
`endif
      for (int k = 0; k < 4; k++) begin
         launch(0, xs[k], rs[k], ms[k], 1'b0);
         wait_done(0, 1'b0, e, yv);
         total++; if (yv !== es[k]) begin bad++; $display("FAIL directed_y[%0d] got=%h exp=%h", k, yv, es[k]); end
         total++; if (e != 33) begin bad++; $display("FAIL directed_lat[%0d] got=%0d exp=33", k, e); end
         @(negedge clk);
         total++; if (done1 !== 1'b0 || busy1 !== 1'b0)
            begin bad++; $display("FAIL directed_idle[%0d] got done=%b busy=%b exp 0/0", k, done1, busy1); end
      end
   endtask

   task automatic test_random(input int sel, input int nvec, input int lat);
      logic [W-1:0] xv, rv, yv, ev;
      logic         mv;
      int           e;
      for (int k = 0; k < nvec; k++) begin
         xv = $urandom; rv = $urandom; mv = 1'($urandom_range(0, 1));
         ev = model(xv, rv, mv);
         launch(sel, xv, rv, mv, 1'b0);
         total++;
         if (((sel != 0) ? busy8 : busy1) !== 1'b1)
            begin bad++; $display("FAIL rand_busy sel=%0d vec=%0d got=0 exp=1", sel, k); end
         wait_done(sel, 1'b1, e, yv);
         total++; if (yv !== ev)
            begin bad++; $display("FAIL rand_y sel=%0d vec=%0d x=%h r=%h m=%b got=%h exp=%h", sel, k, xv, rv, mv, yv, ev); end
         total++; if (e != lat)
            begin bad++; $display("FAIL rand_lat sel=%0d vec=%0d got=%0d exp=%0d", sel, k, e, lat); end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] yv;
      int           e;
      int           seen;
      launch(0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (y1 !== '0)     begin bad++; $display("FAIL abort_y got=%h exp=0", y1); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy1); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (done1 === 1'b1) seen++;
         @(negedge clk);
      end
      total++; if (seen != 0) begin bad++; $display("FAIL abort_done got=%0d pulses exp=0", seen); end
      launch(0, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 1'b0);
      wait_done(0, 1'b1, e, yv);
      total++; if (yv !== mix_fwd(32'hCAFEF00D, 32'h0BADBEEF))
         begin bad++; $display("FAIL abort_rerun_y got=%h exp=%h", yv, mix_fwd(32'hCAFEF00D, 32'h0BADBEEF)); end
      total++; if (e != 33) begin bad++; $display("FAIL abort_rerun_lat got=%0d exp=33", e); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, a2, b2, yv;
      int           e;
      a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
      launch(0, a, b, 1'b0, 1'b1);
      x1 = a2; r1 = b2;
      wait_done(0, 1'b0, e, yv);
      total++; if (yv !== mix_fwd(a, b)) begin bad++; $display("FAIL b2b_y1 got=%h exp=%h", yv, mix_fwd(a, b)); end
      total++; if (e != 33) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=33", e); end
      @(negedge clk);
      total++; if (busy1 !== 1'b1 || done1 !== 1'b0)
         begin bad++; $display("FAIL b2b_restart got busy=%b done=%b exp 1/0", busy1, done1); end
      st1 = 1'b0;
      wait_done(0, 1'b0, e, yv);
      total++; if (yv !== mix_fwd(a2, b2)) begin bad++; $display("FAIL b2b_y2 got=%h exp=%h", yv, mix_fwd(a2, b2)); end
      total++; if (e != 33) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=33", e); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(1, 1000, 5);
      test_random(0, 40, 33);
      test_reset_midrun();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nmix_engine.md
NMIX_ENGINE -- requirements
Module: nmix_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (≥2).
REQ-002 SHALL have parameter BPC, default 1, meaning bits processed per cycle; must divide WIDTH; elaboration error otherwise.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin an operation.
REQ-006 SHALL have port mode, input, 1; 0 = forward mix, 1 = inverse (unmix).
REQ-007 SHALL have port x, input, WIDTH; the data operand (Y operand in inverse mode).
REQ-008 SHALL have port r, input, WIDTH; the key/random operand.
REQ-009 SHALL have port y, output, WIDTH; the result, registered.
REQ-010 SHALL have port busy, output, 1; high while the operation runs.
REQ-011 SHALL have port done, output, 1; one-cycle pulse when y is valid.

Function
REQ-012 Forward: y[i] SHALL = x[i] ^ r[i] ^ c[i], with c[0]=0 and c[i] = XOR of x[j]&r[j] for j<i (bit 0 included, unlike the legacy block).
REQ-013 Inverse: y[i] SHALL = x[i] ^ r[i] ^ c[i], with c[i] = XOR of y[j]&r[j] for j<i, so inverse(forward(X,R),R)=X.
REQ-014 SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after WIDTH/BPC chunk cycles; DONE->RUN on start, else DONE->IDLE.
REQ-015 start SHALL be accepted only in IDLE or DONE; x, r, mode SHALL be captured on the accepting edge; start during RUN SHALL be ignored.
REQ-016 Each RUN cycle SHALL process BPC bits, LSB chunk first, updating the running parity c.
REQ-017 Latency: with N = WIDTH/BPC and start accepted at edge E0, chunks SHALL be processed at edges E1..EN, and done=1 with y valid in the cycle after EN.
REQ-018 busy SHALL be 1 exactly while state is RUN; done SHALL be 1 exactly while state is DONE.
REQ-019 y SHALL hold its last result until the next accepted start; it SHALL NOT be guaranteed valid while busy=1.
REQ-020 Input changes on x, r, mode after capture SHALL NOT affect the running operation.

Reset
REQ-021 reset SHALL take priority over start; it SHALL force IDLE, y=0, busy=0, done=0, c=0, chunk counter=0.
REQ-022 reset asserted mid-RUN SHALL abort without a done pulse.

Configuration
REQ-023 With macro NMIX_INV_EN defined, inverse mode per REQ-013 SHALL be compiled in.
REQ-024 Without NMIX_INV_EN, the mode input SHALL be ignored and every operation SHALL be forward.

Structure
REQ-025 Package nmix_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the mode constants MODE_FWD=0, MODE_INV=1.
REQ-026 Sub-module nmix_slice SHALL implement the combinational BPC-bit chunk (inputs: x chunk, r chunk, carry-in, mode; outputs: y chunk, carry-out).

Verification (WIDTH=32 unless noted)
REQ-027 x=0, r=0, forward -> y=32'h00000000, done after 33 cycles at BPC=1.
REQ-028 x=32'hFFFFFFFF, r=32'hFFFFFFFF, forward -> y=32'hAAAAAAAA.
REQ-029 x=32'h00000001, r=32'h00000001, forward -> y=32'hFFFFFFFE; then inverse with x=32'hFFFFFFFE, r=1 -> y=32'h00000001 (NMIX_INV_EN defined).
REQ-030 BPC=8, random x/r, 1000 vectors -> y matches the REQ-012 model; done 5 cycles after start.
REQ-031 reset pulsed at chunk 10 of a RUN -> no done pulse, y=0, busy=0; a new start completes normally.
REQ-032 start held high through RUN, then back-to-back start in DONE -> second operation begins immediately with no IDLE cycle; in-RUN starts ignored.
